cdb_arbiter: RTL and testbench

- Producer end of the common data bus (CDB). The dispatcher, the reservation stations and the register-status logic all consume it.
- Collects completed results from up to NUM_SRC execution units (int ALU, branch, mult, load/store). Holds each result in a one-entry per-source buffer.
- Picks one buffered result per cycle by round-robin and broadcasts it on registered cdb_* outputs.
- Output port names match the CDB inputs on the dispatcher so the two connect directly.

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: producer end of the common data bus.
//
// Each execution unit hands its completed result into a one-entry buffer.
// A round-robin arbiter picks one buffered result per cycle and broadcasts
// it on the registered cdb_* outputs.
//
// Handshake: a source transfers a result on a clock edge where
// i_src_valid[i] && o_src_ready[i]. o_src_ready depends only on
// registered state, i_rst_n and i_flush, never on i_src_valid.
// A source that is being granted this cycle is ready again at once, so a
// single source can stream one result per cycle.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_flush             discard every buffered, unbroadcast result
//   i_src_valid/ready   per-source handshake
//   i_src_tag/data      packed per-source tag and result data
//   i_src_branch/taken  per-source branch-resolution flags
//   cdb_*               registered broadcast
//   o_grant             one-hot source whose result is on the CDB now
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NUM_SRC-1:0]        i_src_valid,
  output logic [NUM_SRC-1:0]        o_src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  i_src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]        i_src_branch,
  input  logic [NUM_SRC-1:0]        i_src_taken,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      cdb_branch,
  output logic                      cdb_branch_taken,
  output logic [NUM_SRC-1:0]        o_grant
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  // Per-source result buffers
  logic [NUM_SRC-1:0] hold_v;
  logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
  logic [DATA_W-1:0]  hold_data [NUM_SRC];
  logic [NUM_SRC-1:0] hold_branch;
  logic [NUM_SRC-1:0] hold_taken;

  logic [PTR_W-1:0]   rr_ptr;

  logic [NUM_SRC-1:0] grant_now;
  logic [NUM_SRC-1:0] accept;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   scan_idx;
  logic               win_found;
  logic [PTR_W-1:0]   rr_next;

  // Round-robin search: first held entry at or after rr_ptr, wrapping.
  always_comb begin
    grant_now = '0;
    win       = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!win_found && hold_v[scan_idx]) begin
        win_found = 1'b1;
        win       = scan_idx;
      end
    end
    if (win_found) begin
      grant_now[win] = 1'b1;
    end
  end

  assign rr_next = (win == LAST_IDX) ? '0 : win + PTR_W'(1);

  // A granted entry is vacated at this edge, so it can be refilled now.
  assign o_src_ready = (~hold_v | grant_now) & {NUM_SRC{i_rst_n & ~i_flush}};
  assign accept      = i_src_valid & o_src_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_v           <= '0;
      hold_branch      <= '0;
      hold_taken       <= '0;
      rr_ptr           <= '0;
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      o_grant          <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_tag[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (i_flush) begin
      // The broadcast already on the bus this cycle stays; nothing new follows.
      hold_v           <= '0;
      rr_ptr           <= '0;
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      o_grant          <= '0;
    end else begin
      cdb_valid <= win_found;
      o_grant   <= grant_now;
      if (win_found) begin
        cdb_tag          <= hold_tag[win];
        cdb_data         <= hold_data[win];
        cdb_branch       <= hold_branch[win];
        cdb_branch_taken <= hold_taken[win] & hold_branch[win];
        rr_ptr           <= rr_next;
      end else begin
        cdb_tag          <= '0;
        cdb_data         <= '0;
        cdb_branch       <= 1'b0;
        cdb_branch_taken <= 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        // A refill wins over the clear so a streaming source never bubbles.
        if (accept[i]) begin
          hold_v[i]      <= 1'b1;
          hold_tag[i]    <= i_src_tag[i*TAG_W +: TAG_W];
          hold_data[i]   <= i_src_data[i*DATA_W +: DATA_W];
          hold_branch[i] <= i_src_branch[i];
          hold_taken[i]  <= i_src_taken[i];
        end else if (grant_now[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              flush;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*TW-1:0]   src_tag;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_branch;
  logic [N-1:0]      src_taken;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic              cdb_branch;
  logic              cdb_branch_taken;
  logic [N-1:0]      grant;

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_flush          (flush),
    .i_src_valid      (src_valid),
    .o_src_ready      (src_ready),
    .i_src_tag        (src_tag),
    .i_src_data       (src_data),
    .i_src_branch     (src_branch),
    .i_src_taken      (src_taken),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken),
    .o_grant          (grant)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Buffers are plain arrays; arbitration is a modular scan from the pointer.
  bit              m_hv   [N];
  logic [TW-1:0]   m_tag  [N];
  logic [DW-1:0]   m_data [N];
  bit              m_br   [N];
  bit              m_tk   [N];
  int              m_rr;
  bit              m_cv, m_cbr, m_ctk;
  logic [TW-1:0]   m_ctag;
  logic [DW-1:0]   m_cdata;
  logic [N-1:0]    m_grant;

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      if (m_hv[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_b
    int w;
    bit rdy [N];
    if (!rst_n || flush) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_rr = 0; m_cv = 0; m_ctag = '0; m_cdata = '0; m_cbr = 0; m_ctk = 0; m_grant = '0;
    end else begin
      w = m_winner();
      for (int i = 0; i < N; i++) rdy[i] = !m_hv[i] || (i == w);
      if (w >= 0) begin
        m_cv    = 1'b1;
        m_ctag  = m_tag[w];
        m_cdata = m_data[w];
        m_cbr   = m_br[w];
        m_ctk   = m_br[w] && m_tk[w];
        m_grant = N'(1 << w);
        m_rr    = (w + 1) % N;
        m_hv[w] = 1'b0;
      end else begin
        m_cv = 0; m_ctag = '0; m_cdata = '0; m_cbr = 0; m_ctk = 0; m_grant = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && rdy[i]) begin
          m_hv[i]   = 1'b1;
          m_tag[i]  = src_tag[i*TW +: TW];
          m_data[i] = src_data[i*DW +: DW];
          m_br[i]   = src_branch[i];
          m_tk[i]   = src_taken[i];
        end
      end
    end
  end

  // Every cycle, compare the DUT against the model away from the active edge.
  always @(negedge clk) begin : model_chk
    int w;
    logic [N-1:0] er;
    if (chk_en) begin
      w = m_winner();
      for (int i = 0; i < N; i++) er[i] = rst_n && !flush && (!m_hv[i] || i == w);
      chk("m_cdb_valid", 32'(cdb_valid), 32'(m_cv));
      chk("m_cdb_tag", 32'(cdb_tag), 32'(m_ctag));
      chk("m_cdb_data", cdb_data, m_cdata);
      chk("m_cdb_branch", 32'(cdb_branch), 32'(m_cbr));
      chk("m_cdb_taken", 32'(cdb_branch_taken), 32'(m_ctk));
      chk("m_grant", 32'(grant), 32'(er == er ? m_grant : m_grant));
      chk("m_ready", 32'(src_ready), 32'(er));
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic         rst_n;
    logic         flush;
    logic [3:0]   valid;
    logic [23:0]  tags;
    logic [3:0]   br;
    logic [3:0]   tk;
    logic [127:0] data;
    logic         e_cv;
    logic [5:0]   e_tag;
    logic [31:0]  e_data;
    logic         e_br;
    logic         e_tk;
    logic [3:0]   e_grant;
    logic [3:0]   e_ready;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                              input logic [23:0] t, input logic [3:0] b, input logic [3:0] k,
                              input logic [127:0] d, input logic ecv, input logic [5:0] etag,
                              input logic [31:0] edata, input logic ebr, input logic etk,
                              input logic [3:0] eg, input logic [3:0] er);
    vec_t x;
    x.rst_n = r; x.flush = f; x.valid = v; x.tags = t; x.br = b; x.tk = k; x.data = d;
    x.e_cv = ecv; x.e_tag = etag; x.e_data = edata; x.e_br = ebr; x.e_tk = etk;
    x.e_grant = eg; x.e_ready = er;
    return x;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] v, input logic [23:0] t,
                       input logic [3:0] b, input logic [3:0] k, input logic [127:0] d);
    rst_n = r; flush = f; src_valid = v; src_tag = t; src_branch = b; src_taken = k; src_data = d;
  endtask

  localparam logic [23:0]  T1234 = {6'h4, 6'h3, 6'h2, 6'h1};
  localparam logic [23:0]  TFULL = {6'h3D, 6'h3C, 6'h3B, 6'h3A};
  localparam logic [127:0] DBEEF = {32'h0, 32'hDEADBEEF, 64'h0};

  initial begin
    drive(1'b0, 1'b0, 4'h0, '0, '0, '0, '0);
    next_cycle();
    chk_en = 1'b1;

    // reset held 3 cycles with all sources valid, then release
    vt.push_back(mk(0,0,4'hF,T1234,0,0,0, 0,0,0,0,0,4'h0,4'h0));
    vt.push_back(mk(0,0,4'hF,T1234,0,0,0, 0,0,0,0,0,4'h0,4'h0));
    vt.push_back(mk(0,0,4'hF,T1234,0,0,0, 0,0,0,0,0,4'h0,4'h0));
    vt.push_back(mk(1,0,4'h0,0,0,0,0,     0,0,0,0,0,4'h0,4'hF));
    // single result from src2
    vt.push_back(mk(1,0,4'b0100,{6'h0,6'h15,6'h0,6'h0},0,0,DBEEF, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h15,32'hDEADBEEF,0,0,4'b0100,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    // brief reset to return the pointer to 0
    vt.push_back(mk(0,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'h0));
    // contention: all four sources at once
    vt.push_back(mk(1,0,4'hF,T1234,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'b0001));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h1,0,0,0,4'b0001,4'b0011));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h2,0,0,0,4'b0010,4'b0111));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h3,0,0,0,4'b0100,4'hF));
    // wrap-around: src0 and src3 pending after src3 granted
    vt.push_back(mk(1,0,4'b1001,{6'h23,6'h0,6'h0,6'h20},0,0,0, 1,6'h4,0,0,0,4'b1000,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'b0111));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h20,0,0,0,4'b0001,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h23,0,0,0,4'b1000,4'hF));
    // branch taken, then not-a-branch with taken set (refill during grant)
    vt.push_back(mk(1,0,4'b0010,{6'h0,6'h0,6'h31,6'h0},4'b0010,4'b0010,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'b0010,{6'h0,6'h0,6'h32,6'h0},4'b0000,4'b0010,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h31,0,1,1,4'b0010,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 1,6'h32,0,0,0,4'b0010,4'hF));
    // fill all buffers, flush (with valid still high), nothing ever appears
    vt.push_back(mk(1,0,4'hF,TFULL,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,1,4'hF,TFULL,0,0,0, 0,0,0,0,0,4'h0,4'h0));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'hF));
    vt.push_back(mk(1,0,4'h0,0,0,0,0, 0,0,0,0,0,4'h0,4'hF));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].flush, vt[i].valid, vt[i].tags, vt[i].br, vt[i].tk, vt[i].data);
      @(negedge clk);
      chk($sformatf("v%0d_cdb_valid", i), 32'(cdb_valid), 32'(vt[i].e_cv));
      chk($sformatf("v%0d_cdb_tag", i), 32'(cdb_tag), 32'(vt[i].e_tag));
      chk($sformatf("v%0d_cdb_data", i), cdb_data, vt[i].e_data);
      chk($sformatf("v%0d_cdb_branch", i), 32'(cdb_branch), 32'(vt[i].e_br));
      chk($sformatf("v%0d_cdb_taken", i), 32'(cdb_branch_taken), 32'(vt[i].e_tk));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].e_grant));
      chk($sformatf("v%0d_ready", i), 32'(src_ready), 32'(vt[i].e_ready));
      next_cycle();
    end

    // streaming: src0 presents tags 0..9 on consecutive cycles
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, 1'b0, (c < 10) ? 4'b0001 : 4'b0000, 24'(c % 10), 4'h0, 4'h0, 128'(c));
      @(negedge clk);
      if (c < 10) chk($sformatf("stream_ready_c%0d", c), 32'(src_ready[0]), 32'd1);
      if (c >= 2 && c < 12) begin
        chk($sformatf("stream_valid_c%0d", c), 32'(cdb_valid), 32'd1);
        chk($sformatf("stream_tag_c%0d", c), 32'(cdb_tag), 32'(c - 2));
      end else begin
        chk($sformatf("stream_idle_c%0d", c), 32'(cdb_valid), 32'd0);
      end
      next_cycle();
    end

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 127) != 0), ($urandom_range(0, 31) == 0), 4'($urandom),
            24'($urandom), 4'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      next_cycle();
    end

    drive(1'b1, 1'b0, 4'h0, '0, '0, '0, '0);
    repeat (8) next_cycle();
    @(negedge clk);
    chk_en = 1'b0;
    chk("drain_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("drain_ready", 32'(src_ready), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
